ctrl_bubble_stage: RTL and testbench

//   Registered ID/EX control stage with multi-cycle bubble insertion. Replaces the combinational

---
 rtl/ctrl_bubble_stage.sv | 73 +++++++
 tb/tb_ctrl_bubble_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ctrl_bubble_stage.sv
// ctrl_bubble_stage: registered ID/EX control stage that captures a hazarding bundle,
// issues hazard_len_i NOP bubbles, then replays it; with stall hold, flush and bubble counter.
module ctrl_bubble_stage #(
  parameter int                CTRL_W    = 12,
  parameter logic [CTRL_W-1:0] NOP_VALUE = '0,
  parameter int                LEN_W     = 2,
  parameter int                CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              valid_i,
  input  logic              hazard_i,
  input  logic [LEN_W-1:0]  hazard_len_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              valid_o,
  output logic              stall_up_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);
  typedef enum logic {RUN, BUBBLE} state_t;
  state_t            state;
  logic [CTRL_W-1:0] hold_q;
  logic [LEN_W-1:0]  rem;
  logic              enter;
  logic              load_bubble;
  always_comb begin
    enter       = state == RUN && hazard_i && valid_i && |hazard_len_i;
    load_bubble = !flush_i && !stall_i && (enter || (state == BUBBLE && |rem));
  end
  assign stall_up_o = state == BUBBLE || stall_i;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= RUN;
      hold_q  <= '0;
      rem     <= '0;
      ctrl_o  <= NOP_VALUE;
      valid_o <= 1'b0;
    end else if (flush_i) begin
      state   <= RUN;
      rem     <= '0;
      ctrl_o  <= NOP_VALUE;
      valid_o <= 1'b0;
    end else if (!stall_i) begin
      if (state == RUN) begin
        if (enter) begin
          hold_q  <= ctrl_i;
          rem     <= hazard_len_i - LEN_W'(1);
          ctrl_o  <= NOP_VALUE;
          valid_o <= 1'b0;
          state   <= BUBBLE;
        end else begin
          ctrl_o  <= ctrl_i;
          valid_o <= valid_i;
        end
      end else if (|rem) begin
        rem     <= rem - LEN_W'(1);
        ctrl_o  <= NOP_VALUE;
        valid_o <= 1'b0;
      end else begin
        ctrl_o  <= hold_q;
        valid_o <= 1'b1;
        state   <= RUN;
      end
    end
  end
  // Counts hazard bubbles only; flush and stall NOPs are not performance bubbles.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) bubble_cnt_o <= '0;
    else if (load_bubble && !(&bubble_cnt_o)) bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
  end
endmodule

// File: tb/tb_ctrl_bubble_stage.sv
// tb_ctrl_bubble_stage: directed vector table, saturation sequence and randomized run
// against a cycle-level reference model; a second instance with CNT_W=2 checks saturation.
module tb_ctrl_bubble_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] ctrl = '0;
  logic        valid = 1'b0, hazard = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [1:0]  len = '0;
  logic [11:0] ctrl_o, s_ctrl;
  logic        valid_o, stall_up, s_valid, s_stall_up;
  logic [15:0] cnt;
  logic [1:0]  s_cnt;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  ctrl_bubble_stage dut (
    .clk_i(clk), .rst_n_i(rst_n), .ctrl_i(ctrl), .valid_i(valid), .hazard_i(hazard),
    .hazard_len_i(len), .stall_i(stall), .flush_i(flush), .ctrl_o(ctrl_o),
    .valid_o(valid_o), .stall_up_o(stall_up), .bubble_cnt_o(cnt)
  );
  ctrl_bubble_stage #(.CNT_W(2)) sat (
    .clk_i(clk), .rst_n_i(rst_n), .ctrl_i(ctrl), .valid_i(valid), .hazard_i(hazard),
    .hazard_len_i(len), .stall_i(stall), .flush_i(flush), .ctrl_o(s_ctrl),
    .valid_o(s_valid), .stall_up_o(s_stall_up), .bubble_cnt_o(s_cnt)
  );

  typedef struct {
    logic        rst_n;
    logic [11:0] ctrl;
    logic        valid, hazard;
    logic [1:0]  len;
    logic        stall, flush;
    logic        e_su;
    logic [11:0] e_ctrl;
    logic        e_valid;
    int          e_cnt;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t v(logic r, logic [11:0] c, logic va, logic h, logic [1:0] l,
                             logic s, logic f, logic su, logic [11:0] ec, logic ev, int en);
    vec_t x;
    x.rst_n = r; x.ctrl = c; x.valid = va; x.hazard = h; x.len = l; x.stall = s; x.flush = f;
    x.e_su = su; x.e_ctrl = ec; x.e_valid = ev; x.e_cnt = en;
    return x;
  endfunction

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  function automatic int sat3(int c);
    return c > 3 ? 3 : c;
  endfunction

  task automatic drive(logic r, logic [11:0] c, logic va, logic h, logic [1:0] l, logic s, logic f);
    @(negedge clk);
    rst_n = r; ctrl = c; valid = va; hazard = h; len = l; stall = s; flush = f;
    #1;
  endtask

  task automatic run_vec(vec_t x, string tag);
    drive(x.rst_n, x.ctrl, x.valid, x.hazard, x.len, x.stall, x.flush);
    chk({tag, ".stall_up"}, int'(stall_up), int'(x.e_su));
    @(posedge clk); #1;
    chk({tag, ".ctrl"}, int'(ctrl_o), int'(x.e_ctrl));
    chk({tag, ".valid"}, int'(valid_o), int'(x.e_valid));
    chk({tag, ".cnt"}, int'(cnt), x.e_cnt);
    chk({tag, ".sat_cnt"}, int'(s_cnt), sat3(x.e_cnt));
  endtask

  // Reference model: a held instruction waiting behind a number of NOPs still owed.
  logic [11:0] m_ctrl, m_held;
  logic        m_valid, m_have;
  int          m_left, m_cnt;

  task automatic rand_step(int k);
    logic r, va, h, s, f;
    logic [11:0] c;
    logic [1:0] l;
    r  = $urandom_range(99) != 0;
    c  = 12'($urandom);
    va = $urandom_range(9) < 8;
    h  = $urandom_range(9) < 3;
    l  = 2'($urandom);
    s  = $urandom_range(99) < 15;
    f  = $urandom_range(99) < 5;
    if (k == 0) r = 1'b0;
    drive(r, c, va, h, l, s, f);
    if (!r) begin
      m_have = 0; m_ctrl = '0; m_valid = 0; m_cnt = 0; m_left = 0;
    end
    chk("rand.stall_up", int'(stall_up), int'(m_have || s));
    if (r) begin
      if (f) begin
        m_have = 0; m_ctrl = '0; m_valid = 0;
      end else if (!s) begin
        if (m_have && m_left > 0) begin
          m_left--; m_ctrl = '0; m_valid = 0; m_cnt++;
        end else if (m_have) begin
          m_have = 0; m_ctrl = m_held; m_valid = 1;
        end else if (h && va && l != 0) begin
          m_have = 1; m_held = c; m_left = int'(l) - 1; m_ctrl = '0; m_valid = 0; m_cnt++;
        end else begin
          m_ctrl = c; m_valid = va;
        end
      end
    end
    @(posedge clk); #1;
    chk("rand.ctrl", int'(ctrl_o), int'(m_ctrl));
    chk("rand.valid", int'(valid_o), int'(m_valid));
    chk("rand.cnt", int'(cnt), m_cnt);
    chk("rand.sat_cnt", int'(s_cnt), sat3(m_cnt));
  endtask

  initial begin
    // rst, ctrl, valid, haz, len, stall, flush | stall_up, ctrl_o, valid_o, cnt
    vecs.push_back(v(0, 12'hABC, 1, 0, 0, 0, 0, 0, 12'h000, 0, 0));
    vecs.push_back(v(1, 12'h123, 1, 0, 0, 0, 0, 0, 12'h123, 1, 0));
    vecs.push_back(v(1, 12'h123, 1, 0, 0, 0, 0, 0, 12'h123, 1, 0));
    vecs.push_back(v(1, 12'h123, 1, 0, 0, 0, 0, 0, 12'h123, 1, 0));
    vecs.push_back(v(1, 12'h055, 1, 1, 1, 0, 0, 0, 12'h000, 0, 1));
    vecs.push_back(v(1, 12'h000, 0, 0, 0, 0, 0, 1, 12'h055, 1, 1));
    vecs.push_back(v(1, 12'h000, 0, 0, 0, 0, 0, 0, 12'h000, 0, 1));
    vecs.push_back(v(1, 12'h3A5, 1, 1, 3, 0, 0, 0, 12'h000, 0, 2));
    vecs.push_back(v(1, 12'h000, 0, 0, 0, 1, 0, 1, 12'h000, 0, 2));
    vecs.push_back(v(1, 12'h000, 0, 0, 0, 1, 0, 1, 12'h000, 0, 2));
    vecs.push_back(v(1, 12'h000, 0, 0, 0, 0, 0, 1, 12'h000, 0, 3));
    vecs.push_back(v(1, 12'h000, 0, 0, 0, 0, 0, 1, 12'h000, 0, 4));
    vecs.push_back(v(1, 12'h000, 0, 0, 0, 0, 0, 1, 12'h3A5, 1, 4));
    vecs.push_back(v(1, 12'h6C6, 1, 1, 3, 0, 0, 0, 12'h000, 0, 5));
    vecs.push_back(v(1, 12'h000, 0, 0, 0, 0, 1, 1, 12'h000, 0, 5));
    vecs.push_back(v(1, 12'h7FF, 1, 0, 0, 0, 0, 0, 12'h7FF, 1, 5));
    vecs.push_back(v(1, 12'h000, 0, 0, 0, 0, 0, 0, 12'h000, 0, 5));
    vecs.push_back(v(1, 12'h111, 0, 1, 2, 0, 0, 0, 12'h111, 0, 5));
    vecs.push_back(v(1, 12'h222, 1, 1, 0, 0, 0, 0, 12'h222, 1, 5));
    vecs.push_back(v(1, 12'h333, 1, 0, 0, 0, 1, 0, 12'h000, 0, 5));
    vecs.push_back(v(1, 12'h444, 1, 0, 0, 0, 0, 0, 12'h444, 1, 5));
    vecs.push_back(v(1, 12'h555, 1, 1, 1, 1, 0, 1, 12'h444, 1, 5));
    vecs.push_back(v(1, 12'h666, 1, 0, 0, 1, 1, 1, 12'h000, 0, 5));
    vecs.push_back(v(1, 12'h0AA, 1, 1, 2, 0, 0, 0, 12'h000, 0, 6));
    vecs.push_back(v(1, 12'h0BB, 1, 1, 3, 0, 0, 1, 12'h000, 0, 7));
    vecs.push_back(v(1, 12'h0EE, 1, 0, 0, 0, 0, 1, 12'h0AA, 1, 7));
    vecs.push_back(v(1, 12'h0CC, 1, 1, 3, 0, 0, 0, 12'h000, 0, 8));
    vecs.push_back(v(0, 12'h0CC, 1, 0, 0, 0, 0, 0, 12'h000, 0, 0));
    vecs.push_back(v(1, 12'h0DD, 1, 0, 0, 0, 0, 0, 12'h0DD, 1, 0));
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Saturation: five len=1 hazards on a 2-bit counter stop at 3.
    drive(0, '0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      drive(1, 12'(12'h100 + i), 1, 1, 1, 0, 0);
      @(posedge clk); #1;
      chk("sat.cnt16", int'(cnt), i + 1);
      chk("sat.cnt2", int'(s_cnt), sat3(i + 1));
      drive(1, '0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("sat.replay", int'(ctrl_o), 12'h100 + i);
      chk("sat.replay_valid", int'(valid_o), 1);
    end

    for (int k = 0; k < 3000; k++) rand_step(k);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
